command_issue_control: RTL and testbench

//  Initiator side of the CAPI PSL command/response protocol: accepts command requests from the CU arbiter,

---
 rtl/command_issue_control.sv | 150 +++++++++++++++
 tb/tb_command_issue_control.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_issue_control.sv
// PSL command issue: tag allocation, credit tracking, registered parity-protected command bus,
// and a per-tag metadata table that the response path reads back on each returning tag.
module command_issue_control #(
  parameter int NUM_TAGS = 32,
  parameter int META_W   = 32
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  input  logic [7:0]        croom,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [12:0]       req_command,
  input  logic [63:0]       req_address,
  input  logic [11:0]       req_size,
  input  logic [2:0]        req_abt,
  input  logic [15:0]       req_context,
  input  logic [META_W-1:0] req_meta,
  output logic              cmd_valid,
  output logic [7:0]        cmd_tag,
  output logic              cmd_tag_parity,
  output logic [12:0]       cmd_command,
  output logic              cmd_command_parity,
  output logic [63:0]       cmd_address,
  output logic              cmd_address_parity,
  output logic [2:0]        cmd_abt,
  output logic [15:0]       cmd_context,
  output logic [11:0]       cmd_size,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_tag,
  input  logic [8:0]        rsp_credits,
  output logic [META_W-1:0] rsp_meta,
  output logic              rsp_meta_valid,
  output logic [8:0]        outstanding,
  output logic [8:0]        credits,
  output logic [2:0]        issue_error,
  output logic [1:0]        dbg_state
);
  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam logic [8:0] NUM_TAGS_9 = 9'(NUM_TAGS);

  // Handshake: a request transfers on a clock edge where req_valid and req_ready are both high;
  // req_ready depends only on registered state, never on req_valid.
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RISE = 2'd1, ST_RUN = 2'd2} en_state_t;
  en_state_t state, state_next;

  logic [NUM_TAGS-1:0] busy, busy_next;
  logic [META_W-1:0]   meta_tbl [NUM_TAGS];
  logic [8:0]          croom_lat;
  logic                any_free;
  logic [TAG_W-1:0]    alloc_idx;
  logic [TAG_W-1:0]    rsp_idx;
  logic                rsp_in_range, rsp_hit, accept, run_active, overflow;
  logic [10:0]         credit_sum;
  logic [7:0]          alloc_tag;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= ST_OFF;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enabled_in) state_next = ST_OFF;
    else begin
      case (state)
        ST_OFF:  state_next = ST_RISE;
        ST_RISE: state_next = ST_RUN;
        default: state_next = ST_RUN;
      endcase
    end
  end

  assign dbg_state = state;

  // Lowest-numbered free tag wins: scan downward so the last hit is the smallest index.
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free  = 1'b1;
        alloc_idx = TAG_W'(i);
      end
    end
  end

  assign req_ready    = (state == ST_RUN) && !credits[8] && (credits != 9'd0) && any_free;
  assign accept       = req_valid && req_ready;
  assign run_active   = (state == ST_RUN) && enabled_in;
  assign alloc_tag    = 8'(alloc_idx);
  assign rsp_idx      = rsp_tag[TAG_W-1:0];
  assign rsp_in_range = {1'b0, rsp_tag} < NUM_TAGS_9;
  assign rsp_hit      = rsp_valid && rsp_in_range && busy[rsp_idx];

  // Credit arithmetic in 11 bits so the overflow compare never wraps.
  assign credit_sum = {{2{credits[8]}}, credits} - {10'd0, accept}
                    + (rsp_valid ? {{2{rsp_credits[8]}}, rsp_credits} : 11'd0);
  assign overflow   = $signed(credit_sum) > $signed({2'b00, croom_lat});

  always_comb begin
    busy_next = busy;
    if (accept)  busy_next[alloc_idx] = 1'b1;
    if (rsp_hit) busy_next[rsp_idx]   = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (accept && run_active) meta_tbl[alloc_idx] <= req_meta;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      busy <= '0; outstanding <= '0; credits <= '0; croom_lat <= '0; issue_error <= '0;
      cmd_valid <= 1'b0; cmd_tag <= '0; cmd_command <= '0; cmd_address <= '0;
      cmd_abt <= '0; cmd_context <= '0; cmd_size <= '0;
      cmd_tag_parity <= 1'b0; cmd_command_parity <= 1'b0; cmd_address_parity <= 1'b0;
      rsp_meta <= '0; rsp_meta_valid <= 1'b0;
    end else if (!run_active) begin
      // Disabled or in the enable-rise cycle: pool empty, bus idle; rise loads the credits.
      busy <= '0; outstanding <= '0; issue_error <= '0;
      credits   <= (enabled_in && state == ST_RISE) ? {1'b0, croom} : 9'd0;
      croom_lat <= (enabled_in && state == ST_RISE) ? {1'b0, croom} : 9'd0;
      cmd_valid <= 1'b0; cmd_tag <= '0; cmd_command <= '0; cmd_address <= '0;
      cmd_abt <= '0; cmd_context <= '0; cmd_size <= '0;
      cmd_tag_parity <= 1'b0; cmd_command_parity <= 1'b0; cmd_address_parity <= 1'b0;
      rsp_meta <= '0; rsp_meta_valid <= 1'b0;
    end else begin
      busy        <= busy_next;
      outstanding <= outstanding + 9'(accept) - 9'(rsp_hit);
      credits     <= overflow ? croom_lat : credit_sum[8:0];
      issue_error <= {overflow,
                      rsp_valid && rsp_in_range && !busy[rsp_idx],
                      rsp_valid && !rsp_in_range};
      cmd_valid   <= accept;
      if (accept) begin
        cmd_tag            <= alloc_tag;
        cmd_command        <= req_command;
        cmd_address        <= req_address;
        cmd_abt            <= req_abt;
        cmd_context        <= req_context;
        cmd_size           <= req_size;
        cmd_tag_parity     <= ~^alloc_tag;
        cmd_command_parity <= ~^req_command;
        cmd_address_parity <= ~^req_address;
      end
      rsp_meta_valid <= rsp_hit;
      rsp_meta       <= rsp_hit ? meta_tbl[rsp_idx] : '0;
    end
  end
endmodule

// File: tb/tb_command_issue_control.sv
// Bench for command_issue_control: directed scenarios plus randomized traffic against a tag-pool model.
module tb_command_issue_control;
  localparam int NT = 32;
  localparam int MW = 32;

  logic          clock = 1'b0;
  logic          rstn = 1'b0;
  logic          enabled_in = 1'b0;
  logic [7:0]    croom = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [12:0]   req_command = '0;
  logic [63:0]   req_address = '0;
  logic [11:0]   req_size = '0;
  logic [2:0]    req_abt = '0;
  logic [15:0]   req_context = '0;
  logic [MW-1:0] req_meta = '0;
  logic          cmd_valid, cmd_tag_parity, cmd_command_parity, cmd_address_parity;
  logic [7:0]    cmd_tag;
  logic [12:0]   cmd_command;
  logic [63:0]   cmd_address;
  logic [2:0]    cmd_abt;
  logic [15:0]   cmd_context;
  logic [11:0]   cmd_size;
  logic          rsp_valid = 1'b0;
  logic [7:0]    rsp_tag = '0;
  logic [8:0]    rsp_credits = '0;
  logic [MW-1:0] rsp_meta;
  logic          rsp_meta_valid;
  logic [8:0]    outstanding, credits;
  logic [2:0]    issue_error;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;

  command_issue_control #(.NUM_TAGS(NT), .META_W(MW)) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .croom(croom),
    .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
    .req_address(req_address), .req_size(req_size), .req_abt(req_abt),
    .req_context(req_context), .req_meta(req_meta),
    .cmd_valid(cmd_valid), .cmd_tag(cmd_tag), .cmd_tag_parity(cmd_tag_parity),
    .cmd_command(cmd_command), .cmd_command_parity(cmd_command_parity),
    .cmd_address(cmd_address), .cmd_address_parity(cmd_address_parity),
    .cmd_abt(cmd_abt), .cmd_context(cmd_context), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_credits(rsp_credits),
    .rsp_meta(rsp_meta), .rsp_meta_valid(rsp_meta_valid),
    .outstanding(outstanding), .credits(credits), .issue_error(issue_error),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Reference model: tag pool as a bit array, credits as a plain integer.
  bit            m_busy [NT];
  logic [MW-1:0] m_meta [NT];
  int            m_credits, m_croom, m_phase;  // phase 0 disabled, 1 enable-rise, 2 running
  bit            e_cmd_valid, e_rsp_mv;
  int            e_tag, e_out;
  logic [12:0]   e_command;
  logic [63:0]   e_address;
  logic [2:0]    e_abt, e_err;
  logic [15:0]   e_context;
  logic [11:0]   e_size;
  logic [MW-1:0] e_rsp_meta;

  function automatic int lowest_free();
    for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit m_ready();
    return (m_phase == 2) && (m_credits > 0) && (lowest_free() >= 0);
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NT; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NT; i++) m_busy[i] = 1'b0;
    m_credits = 0; m_croom = 0;
    e_cmd_valid = 0; e_rsp_mv = 0; e_out = 0; e_err = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then step the DUT.
  task automatic tick();
    int  ftag, rt, newc;
    bit  acc, rel;
    ftag = lowest_free();
    acc  = req_valid && m_ready();
    rt   = int'(rsp_tag);
    if (!enabled_in || m_phase == 0) begin
      model_clear();
      m_phase = enabled_in ? 1 : 0;
    end else if (m_phase == 1) begin
      model_clear();
      m_credits = int'(croom); m_croom = int'(croom); m_phase = 2;
    end else begin
      rel  = rsp_valid && rt < NT && m_busy[rt];
      newc = m_credits - int'(acc) + (rsp_valid ? int'($signed(rsp_credits)) : 0);
      e_err = {newc > m_croom, rsp_valid && rt < NT && !m_busy[rt], rsp_valid && rt >= NT};
      m_credits = (newc > m_croom) ? m_croom : newc;
      e_rsp_mv = rel;
      if (rel) e_rsp_meta = m_meta[rt];
      e_cmd_valid = acc;
      if (acc) begin
        m_busy[ftag] = 1'b1; m_meta[ftag] = req_meta;
        e_tag = ftag; e_command = req_command; e_address = req_address;
        e_abt = req_abt; e_context = req_context; e_size = req_size;
      end
      if (rel) m_busy[rt] = 1'b0;
      e_out = busy_count();
    end
    @(posedge clock);
    #1;
  endtask

  // Driver tasks
  task automatic drive_idle();
    req_valid = 1'b0; rsp_valid = 1'b0; rsp_tag = '0; rsp_credits = '0;
  endtask

  task automatic drive_req(input logic [63:0] addr);
    req_valid = 1'b1; req_command = 13'($urandom); req_address = addr;
    req_size = 12'($urandom); req_abt = 3'($urandom); req_context = 16'($urandom);
    req_meta = MW'($urandom);
  endtask

  task automatic do_reset();
    drive_idle(); enabled_in = 1'b0; rstn = 1'b0;
    m_phase = 0; model_clear();
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;
  endtask

  task automatic enable(input int c);
    croom = 8'(c); enabled_in = 1'b1;
    tick(); tick();
    total++;
    if (credits !== 9'(c)) begin bad++; $display("FAIL enable_credits got=%0d want=%0d", credits, c); end
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    #3;
    total++;
    if ({cmd_valid, cmd_tag_parity, cmd_command_parity, cmd_address_parity, rsp_meta_valid, req_ready} !== 6'b0 ||
        outstanding !== 9'd0 || credits !== 9'd0 || issue_error !== 3'b0 || cmd_tag !== 8'd0) begin
      bad++; $display("FAIL reset_outputs cv=%b out=%0d cr=%0d err=%b want all zero", cmd_valid, outstanding, credits, issue_error);
    end
    @(posedge clock); #1 rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] metas [4];
    do_reset();
    enable(4);
    for (int k = 0; k < 6; k++) begin
      drive_req(64'($urandom) << 7);
      if (k < 4) metas[k] = req_meta;
      total++;
      if (req_ready !== (k < 4)) begin bad++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, req_ready, k < 4); end
      tick();
      total++;
      if (cmd_valid !== (k < 4)) begin bad++; $display("FAIL b2b_valid k=%0d got=%b want=%b", k, cmd_valid, k < 4); end
      if (k < 4) begin
        total++;
        if (cmd_tag !== 8'(k) || outstanding !== 9'(k + 1) || credits !== 9'(3 - k)) begin
          bad++; $display("FAIL b2b_issue k=%0d tag=%0d out=%0d cr=%0d want tag=%0d out=%0d cr=%0d", k, cmd_tag, outstanding, credits, k, k + 1, 3 - k);
        end
      end
    end
    drive_idle(); rsp_valid = 1'b1; rsp_tag = 8'd2; rsp_credits = 9'd1;
    tick();
    total++;
    if (credits !== 9'd1 || outstanding !== 9'd3 || rsp_meta_valid !== 1'b1 || rsp_meta !== metas[2] || issue_error !== 3'b0) begin
      bad++; $display("FAIL rsp_tag2 cr=%0d out=%0d mv=%b meta=%h want cr=1 out=3 mv=1 meta=%h", credits, outstanding, rsp_meta_valid, rsp_meta, metas[2]);
    end
    drive_idle(); drive_req(64'h10);
    tick();
    total++;
    if (cmd_valid !== 1'b1 || cmd_tag !== 8'd2 || credits !== 9'd0) begin
      bad++; $display("FAIL reuse_tag2 cv=%b tag=%0d cr=%0d want cv=1 tag=2 cr=0", cmd_valid, cmd_tag, credits);
    end
    drive_idle(); rsp_valid = 1'b1; rsp_tag = 8'd1; rsp_credits = 9'd1;
    tick();
    drive_req(64'h20); rsp_valid = 1'b1; rsp_tag = 8'd0; rsp_credits = 9'd1;
    tick();
    total++;
    if (cmd_tag !== 8'd1 || credits !== 9'd1 || outstanding !== 9'd3 || rsp_meta_valid !== 1'b1) begin
      bad++; $display("FAIL acc_and_rsp tag=%0d cr=%0d out=%0d mv=%b want tag=1 cr=1 out=3 mv=1", cmd_tag, credits, outstanding, rsp_meta_valid);
    end
    drive_idle();
  endtask

  task automatic test_parity();
    do_reset();
    enable(8);
    for (int k = 0; k < 4; k++) begin
      drive_req(k == 3 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'($urandom));
      req_command = (k == 2) ? 13'h1FFF : req_command;
      tick();
      total++;
      if (cmd_tag_parity !== ($countones(cmd_tag) % 2 == 0) || cmd_command_parity !== ($countones(e_command) % 2 == 0) ||
          cmd_address_parity !== ($countones(e_address) % 2 == 0) || cmd_command !== e_command || cmd_address !== e_address) begin
        bad++; $display("FAIL parity k=%0d tp=%b cp=%b ap=%b cmd=%h addr=%h want cmd=%h addr=%h", k, cmd_tag_parity, cmd_command_parity, cmd_address_parity, cmd_command, cmd_address, e_command, e_address);
      end
    end
    total++;
    if (cmd_tag !== 8'h03 || cmd_tag_parity !== 1'b1 || cmd_address_parity !== 1'b1) begin
      bad++; $display("FAIL parity_fixed tag=%h tp=%b ap=%b want tag=03 tp=1 ap=1", cmd_tag, cmd_tag_parity, cmd_address_parity);
    end
    drive_idle();
  endtask

  // Continues from test_parity: tags 0..3 busy, credits 4, croom 8.
  task automatic test_errors();
    rsp_valid = 1'b1; rsp_tag = 8'h40; rsp_credits = 9'd0;
    tick();
    total++;
    if (issue_error !== 3'b001 || rsp_meta_valid !== 1'b0) begin bad++; $display("FAIL err_range got=%b mv=%b want 001 mv=0", issue_error, rsp_meta_valid); end
    drive_idle();
    tick();
    total++;
    if (issue_error !== 3'b000) begin bad++; $display("FAIL err_pulse got=%b want 000", issue_error); end
    rsp_valid = 1'b1; rsp_tag = 8'd10; rsp_credits = 9'd0;
    tick();
    total++;
    if (issue_error !== 3'b010 || rsp_meta_valid !== 1'b0 || outstanding !== 9'd4) begin
      bad++; $display("FAIL err_unknown got=%b mv=%b out=%0d want 010 mv=0 out=4", issue_error, rsp_meta_valid, outstanding);
    end
    rsp_tag = 8'd0; rsp_credits = 9'd5;
    tick();
    total++;
    if (issue_error !== 3'b100 || credits !== 9'd8 || outstanding !== 9'd3 || rsp_meta_valid !== 1'b1) begin
      bad++; $display("FAIL err_overflow got=%b cr=%0d out=%0d want 100 cr=8 out=3", issue_error, credits, outstanding);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    int busy_list [$];
    do_reset();
    enable($urandom_range(3, 12));
    for (int cyc = 0; cyc < 2000; cyc++) begin
      drive_idle();
      enabled_in = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) < 6) drive_req(64'($urandom) << 32 | 64'($urandom));
      if ($urandom_range(0, 9) < 5) begin
        busy_list = {};
        for (int i = 0; i < NT; i++) if (m_busy[i]) busy_list.push_back(i);
        rsp_valid = 1'b1;
        rsp_credits = 9'($signed($urandom_range(0, 4)) - 1);
        case ($urandom_range(0, 9))
          0:       rsp_tag = 8'($urandom_range(0, 255));
          1:       rsp_tag = 8'($urandom_range(0, NT - 1));
          default: rsp_tag = (busy_list.size() > 0) ? 8'(busy_list[$urandom_range(0, busy_list.size() - 1)]) : 8'd0;
        endcase
      end
      total++;
      if (req_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_ready()); end
      tick();
      total++;
      if (cmd_valid !== e_cmd_valid) begin bad++; $display("FAIL rnd_cvalid cyc=%0d got=%b want=%b", cyc, cmd_valid, e_cmd_valid); end
      if (e_cmd_valid) begin
        total++;
        if (cmd_tag !== 8'(e_tag) || cmd_command !== e_command || cmd_address !== e_address ||
            cmd_abt !== e_abt || cmd_context !== e_context || cmd_size !== e_size ||
            cmd_tag_parity !== ($countones(8'(e_tag)) % 2 == 0)) begin
          bad++; $display("FAIL rnd_cmd cyc=%0d tag=%0d addr=%h want tag=%0d addr=%h", cyc, cmd_tag, cmd_address, e_tag, e_address);
        end
      end
      total++;
      if (rsp_meta_valid !== e_rsp_mv || (e_rsp_mv && rsp_meta !== e_rsp_meta)) begin
        bad++; $display("FAIL rnd_rsp cyc=%0d mv=%b meta=%h want mv=%b meta=%h", cyc, rsp_meta_valid, rsp_meta, e_rsp_mv, e_rsp_meta);
      end
      total++;
      if (outstanding !== 9'(e_out) || credits !== 9'(m_credits) || issue_error !== e_err) begin
        bad++; $display("FAIL rnd_state cyc=%0d out=%0d cr=%0d err=%b want out=%0d cr=%0d err=%b", cyc, outstanding, $signed(credits), issue_error, e_out, m_credits, e_err);
      end
    end
    drive_idle(); enabled_in = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable(4);
    for (int k = 0; k < 3; k++) begin drive_req(64'($urandom)); tick(); end
    drive_req(64'h55);
    #2 rstn = 1'b0;
    #1;
    total++;
    if (cmd_valid !== 1'b0 || outstanding !== 9'd0 || credits !== 9'd0 || cmd_tag_parity !== 1'b0 || cmd_tag !== 8'd0) begin
      bad++; $display("FAIL midreset_async cv=%b out=%0d cr=%0d tp=%b want all zero", cmd_valid, outstanding, credits, cmd_tag_parity);
    end
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (cmd_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL midreset_hold cv=%b rdy=%b want 0 0", cmd_valid, req_ready); end
    drive_idle(); rstn = 1'b1;
    m_phase = 0; model_clear();
    enable(5);
    total++;
    if (outstanding !== 9'd0) begin bad++; $display("FAIL midreset_out got=%0d want=0", outstanding); end
    drive_req(64'h77);
    tick();
    total++;
    if (cmd_valid !== 1'b1 || cmd_tag !== 8'd0 || credits !== 9'd4) begin
      bad++; $display("FAIL midreset_tag cv=%b tag=%0d cr=%0d want cv=1 tag=0 cr=4", cmd_valid, cmd_tag, credits);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_errors();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
